// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared op/state encodings and default cycle counts for the
//             mult/div sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

   // op field from ctrl_unit
   typedef logic [1:0] op_t;

   localparam op_t OP_MULT = 2'b00;
   localparam op_t OP_DIV  = 2'b01;
   localparam op_t OP_DIVM = 2'b10;
   localparam op_t OP_RSVD = 2'b11;

   // sequencer states
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_RUN   = 3'd1;
   localparam logic [2:0] ST_WRITE = 3'd2;
   localparam logic [2:0] ST_DONE  = 3'd3;
   localparam logic [2:0] ST_EXC   = 3'd4;

   // default unit latencies and counter width
   localparam int DEF_MULT_CYCLES = 32;
   localparam int DEF_DIV_CYCLES  = 32;
   localparam int DEF_CNT_W       = 6;

   // true for the two divide flavours (the only ops that can trap on zero)
   function automatic logic op_is_div(input op_t op);
      return (op == OP_DIV) || (op == OP_DIVM);
   endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq_if
//  Purpose  : Request/control bundle between ctrl_unit (master) and the
//             mult/div sequencer (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_seq_if;
   import muldiv_pkg::*;

   logic start;
   op_t  op;
   logic flush;
   logic divisor_zero;

   logic mult_ctrl;
   logic div_ctrl;
   logic DIVASelect;
   logic DIVBSelect;
   logic MDSelect;
   logic HiCtrl;
   logic LoCtrl;
   logic busy;
   logic done;
   logic div0_excpt;

   modport master (
      output start, op, flush, divisor_zero,
      input  mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect,
             HiCtrl, LoCtrl, busy, done, div0_excpt
   );

   modport slave (
      input  start, op, flush, divisor_zero,
      output mult_ctrl, div_ctrl, DIVASelect, DIVBSelect, MDSelect,
             HiCtrl, LoCtrl, busy, done, div0_excpt
   );

endinterface
`default_nettype wire

// File: rtl/md_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module   : md_cycle_counter
//  Purpose  : Loadable down-counter with zero flag; saturates at zero so it
//             can never wrap back to a large value.
//  Revision : 1.0  initial release
// ============================================================================
module md_cycle_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] r_count;

   // load has priority; decrement stops at zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_val;
      end else if (dec && (r_count != '0)) begin
         r_count <= r_count - CNT_W'(1);
      end
   end

   assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Sequencer for the shared multi-cycle mult/div units and the
//             Hi/Lo registers. Accepts one start/op request, pulses the unit
//             start line, waits N cycles, writes Hi/Lo, then reports done.
//             Divide-by-zero is caught at acceptance and nothing is launched.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic        clk,
   input  logic        reset,
   muldiv_seq_if.slave bus
);

   // counter preload is N-1 so RUN lasts exactly N cycles
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   logic [2:0]       r_state;
   logic [2:0]       w_next;

   logic             w_ready;
   logic             w_accept;
   logic             w_div0;
   logic             w_launch;
   logic             w_is_mult;
   logic             w_cnt_zero;
   logic [CNT_W-1:0] w_load_val;

   logic r_mult_ctrl;
   logic r_div_ctrl;
   logic r_diva_sel;
   logic r_divb_sel;
   logic r_md_sel;
   logic r_hi_ctrl;
   logic r_lo_ctrl;
   logic r_busy;
   logic r_done;
   logic r_div0;

   // a request is only looked at in IDLE or DONE; flush and reserved op squash it
   assign w_ready    = (r_state == ST_IDLE) || (r_state == ST_DONE);
   assign w_accept   = w_ready && bus.start && !bus.flush && (bus.op != OP_RSVD);
   assign w_div0     = w_accept && op_is_div(bus.op) && bus.divisor_zero;
   assign w_launch   = w_accept && !w_div0;
   assign w_is_mult  = (bus.op == OP_MULT);
   assign w_load_val = w_is_mult ? MULT_LOAD : DIV_LOAD;

   md_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .load     (w_launch),
      .load_val (w_load_val),
      .dec      (r_state == ST_RUN),
      .zero     (w_cnt_zero)
   );

   // next-state logic; flush overrides everything
   always_comb begin
      w_next = r_state;
      if (bus.flush) begin
         w_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_div0)        w_next = ST_EXC;
               else if (w_launch) w_next = ST_RUN;
               else               w_next = ST_IDLE;
            end
            ST_RUN:   w_next = w_cnt_zero ? ST_WRITE : ST_RUN;
            ST_WRITE: w_next = ST_DONE;
            ST_EXC:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
         endcase
      end
   end

   // state register and fully registered outputs derived from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_mult_ctrl <= 1'b0;
         r_div_ctrl  <= 1'b0;
         r_diva_sel  <= 1'b0;
         r_divb_sel  <= 1'b0;
         r_md_sel    <= 1'b0;
         r_hi_ctrl   <= 1'b0;
         r_lo_ctrl   <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_div0      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_mult_ctrl <= w_launch && w_is_mult;
         r_div_ctrl  <= w_launch && !w_is_mult;
         r_divb_sel  <= 1'b0;
         r_hi_ctrl   <= (w_next == ST_WRITE);
         r_lo_ctrl   <= (w_next == ST_WRITE);
         r_busy      <= (w_next == ST_RUN) || (w_next == ST_WRITE) || (w_next == ST_EXC);
         r_done      <= (w_next == ST_DONE);
         r_div0      <= (w_next == ST_EXC);
         // operand/result routing is latched at launch and held until the next one
         if (w_launch) begin
            r_md_sel   <= w_is_mult;
            r_diva_sel <= (bus.op == OP_DIVM);
         end
      end
   end

   assign bus.mult_ctrl  = r_mult_ctrl;
   assign bus.div_ctrl   = r_div_ctrl;
   assign bus.DIVASelect = r_diva_sel;
   assign bus.DIVBSelect = r_divb_sel;
   assign bus.MDSelect   = r_md_sel;
   assign bus.HiCtrl     = r_hi_ctrl;
   assign bus.LoCtrl     = r_lo_ctrl;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;
   assign bus.div0_excpt = r_div0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Self-checking bench for muldiv_seq: transaction table, directed
//             multi-cycle sequences and randomized traffic against a
//             timeline-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int MC = 32;
   localparam int DC = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   muldiv_seq_if bus ();

   muldiv_seq #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC),
      .CNT_W       (6)
   ) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // ---------------- reference model: age since acceptance ----------------
   bit   m_active;
   bit   m_exc;
   bit   m_mult;
   int   m_age;
   int   m_n;
   logic m_mds;
   logic m_diva;

   function automatic void model_reset();
      m_active = 0; m_exc = 0; m_mult = 0; m_age = 0; m_n = 0;
      m_mds = 1'b0; m_diva = 1'b0;
   endfunction

   function automatic void model_step(input logic st, input logic [1:0] op,
                                      input logic fl, input logic dz);
      bit rdy;
      rdy = !m_active || (!m_exc && m_age == m_n + 2);
      if (fl) begin
         m_active = 0;
      end else if (rdy && st && op != 2'b11) begin
         m_active = 1;
         m_age    = 1;
         if (op != 2'b00 && dz) begin
            m_exc = 1;
         end else begin
            m_exc  = 0;
            m_mult = (op == 2'b00);
            m_n    = m_mult ? MC : DC;
            m_mds  = m_mult;
            m_diva = (op == 2'b10);
         end
      end else if (m_active) begin
         m_age++;
         if (m_exc || m_age > m_n + 2) m_active = 0;
      end
   endfunction

   function automatic logic [9:0] model_vec();
      bit run;
      run = m_active && !m_exc;
      return {run && m_age == 1 && m_mult,
              run && m_age == 1 && !m_mult,
              m_diva, 1'b0, m_mds,
              run && m_age == m_n + 1,
              run && m_age == m_n + 1,
              m_active && (m_exc || m_age <= m_n + 1),
              run && m_age == m_n + 2,
              m_active && m_exc && m_age == 1};
   endfunction

   function automatic logic [9:0] dut_vec();
      return {bus.mult_ctrl, bus.div_ctrl, bus.DIVASelect, bus.DIVBSelect, bus.MDSelect,
              bus.HiCtrl, bus.LoCtrl, bus.busy, bus.done, bus.div0_excpt};
   endfunction

   // cycle-by-cycle comparison of every output against the model
   initial begin
      logic [9:0] got;
      logic [9:0] exp;
      model_reset();
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst_n) model_reset();
         else model_step(bus.start, bus.op, bus.flush, bus.divisor_zero);
         #1;
         got = dut_vec();
         exp = model_vec();
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL outputs cyc=%0d got=%b exp=%b (mult div diva divb mds hi lo busy done div0)",
                     cyc, got, exp);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout at cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   // issue one request at the next negedge, then record first-seen cycles (1 = t0+1)
   task automatic run_txn(input logic [1:0] o, input logic dz,
                          output int k_mult, output int k_div, output int k_exc,
                          output int k_hi, output int k_done, output int k_busy,
                          output logic mds, output logic diva);
      k_mult = 0; k_div = 0; k_exc = 0; k_hi = 0; k_done = 0; k_busy = 0;
      mds = 1'b0; diva = 1'b0;
      @(negedge clk);
      bus.start = 1'b1; bus.op = o; bus.divisor_zero = dz;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk); #1;
         if (bus.mult_ctrl  && k_mult == 0) k_mult = k;
         if (bus.div_ctrl   && k_div  == 0) k_div  = k;
         if (bus.div0_excpt && k_exc  == 0) k_exc  = k;
         if (bus.HiCtrl     && k_hi   == 0) k_hi   = k;
         if (bus.done       && k_done == 0) k_done = k;
         if (bus.busy       && k_busy == 0) k_busy = k;
         if (k == 1) begin
            mds  = bus.MDSelect;
            diva = bus.DIVASelect;
            @(negedge clk);
            bus.start = 1'b0;
            bus.divisor_zero = 1'($urandom);
         end
      end
   endtask

   // count output activity over n cycles
   task automatic watch(input int n, output int n_mult, output int n_hi,
                        output int n_done, output int n_busy);
      n_mult = 0; n_hi = 0; n_done = 0; n_busy = 0;
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         if (bus.mult_ctrl || bus.div_ctrl) n_mult++;
         if (bus.HiCtrl || bus.LoCtrl)      n_hi++;
         if (bus.done)                      n_done++;
         if (bus.busy)                      n_busy++;
      end
   endtask

   typedef struct {
      logic [1:0] op;
      logic       dz;
      int         e_mult, e_div, e_exc, e_hi, e_done, e_busy;
      bit         chk_sel;
      logic       e_mds, e_diva;
   } vec_t;

   vec_t vt [7];

   // ---------------- stimulus ----------------
   initial begin
      int   km, kd, ke, kh, kdn, kb;
      int   nm, nh, nd, nb;
      int   k;
      bit   found;
      int   n_div;
      logic ms, da;

      bus.start = 1'b0; bus.op = 2'b00; bus.flush = 1'b0; bus.divisor_zero = 1'b0;

      vt[0] = '{OP_MULT, 1'b0, 1, 0, 0, MC+1, MC+2, 1, 1'b1, 1'b1, 1'b0};
      vt[1] = '{OP_MULT, 1'b1, 1, 0, 0, MC+1, MC+2, 1, 1'b1, 1'b1, 1'b0};
      vt[2] = '{OP_DIV,  1'b0, 0, 1, 0, DC+1, DC+2, 1, 1'b1, 1'b0, 1'b0};
      vt[3] = '{OP_DIVM, 1'b0, 0, 1, 0, DC+1, DC+2, 1, 1'b1, 1'b0, 1'b1};
      vt[4] = '{OP_DIVM, 1'b1, 0, 0, 1, 0,    0,    1, 1'b0, 1'b0, 1'b0};
      vt[5] = '{OP_DIV,  1'b1, 0, 0, 1, 0,    0,    1, 1'b0, 1'b0, 1'b0};
      vt[6] = '{OP_RSVD, 1'b0, 0, 0, 0, 0,    0,    0, 1'b0, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset_outputs", int'(dut_vec()), 0);

      // table of single transactions
      for (int i = 0; i < 7; i++) begin
         run_txn(vt[i].op, vt[i].dz, km, kd, ke, kh, kdn, kb, ms, da);
         chk($sformatf("v%0d_mult_cyc", i), km,  vt[i].e_mult);
         chk($sformatf("v%0d_div_cyc",  i), kd,  vt[i].e_div);
         chk($sformatf("v%0d_exc_cyc",  i), ke,  vt[i].e_exc);
         chk($sformatf("v%0d_hi_cyc",   i), kh,  vt[i].e_hi);
         chk($sformatf("v%0d_done_cyc", i), kdn, vt[i].e_done);
         chk($sformatf("v%0d_busy_cyc", i), kb,  vt[i].e_busy);
         if (vt[i].chk_sel) begin
            chk($sformatf("v%0d_mdselect", i),   int'(ms), int'(vt[i].e_mds));
            chk($sformatf("v%0d_divaselect", i), int'(da), int'(vt[i].e_diva));
         end
      end

      // reset low at RUN cycle 10 of a MULT
      @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT; bus.divisor_zero = 1'b0;
      @(negedge clk); bus.start = 1'b0;
      repeat (9) @(negedge clk);
      chk("pre_reset_busy", int'(bus.busy), 1);
      rst_n = 1'b0; #1;
      chk("async_reset_outputs", int'(dut_vec()), 0);
      @(posedge clk); #1;
      chk("reset_hold_outputs", int'(dut_vec()), 0);
      @(negedge clk); rst_n = 1'b1;
      watch(40, nm, nh, nd, nb);
      chk("after_reset_hilo", nh, 0);
      chk("after_reset_done", nd, 0);
      chk("after_reset_busy", nb, 0);

      // start during RUN ignored; start in DONE launches back-to-back
      @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT; bus.divisor_zero = 1'b0;
      k = 0; found = 0; n_div = 0;
      while (!found && k < 80) begin
         @(posedge clk); #1; k++;
         if (bus.div_ctrl) n_div++;
         if (bus.done) found = 1;
         else begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == 5) begin bus.start = 1'b1; bus.op = OP_DIV; end
            if (k == 6) bus.start = 1'b0;
         end
      end
      chk("b2b_first_done_seen", int'(found), 1);
      chk("b2b_first_done_cyc", k, MC + 2);
      chk("start_in_run_ignored", n_div, 0);
      run_txn(OP_DIV, 1'b0, km, kd, ke, kh, kdn, kb, ms, da);
      chk("b2b_second_launch", kd, 1);
      chk("b2b_second_done", kdn, DC + 2);

      // flush at RUN cycle 5
      @(negedge clk); bus.start = 1'b1; bus.op = OP_MULT;
      @(negedge clk); bus.start = 1'b0;
      repeat (4) @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk); #1;
      chk("flush_busy", int'(bus.busy), 0);
      @(negedge clk); bus.flush = 1'b0;
      watch(40, nm, nh, nd, nb);
      chk("flush_no_hilo", nh, 0);
      chk("flush_no_done", nd, 0);

      // flush and start together in IDLE
      @(negedge clk); bus.flush = 1'b1; bus.start = 1'b1; bus.op = OP_DIV; bus.divisor_zero = 1'b0;
      @(negedge clk); bus.flush = 1'b0; bus.start = 1'b0;
      watch(40, nm, nh, nd, nb);
      chk("flush_start_no_launch", nm, 0);
      chk("flush_start_no_busy", nb, 0);

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         bus.start        = ($urandom_range(2) == 0);
         bus.op           = 2'($urandom);
         bus.flush        = ($urandom_range(39) == 0);
         bus.divisor_zero = ($urandom_range(3) == 0);
         rst_n            = ($urandom_range(699) != 0);
      end
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0; rst_n = 1'b1;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
